wb_queue: RTL and testbench
===========================

WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries; the value SHALL be a power of two, 2..8.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  in  1  a writeback result is offered.
REQ-005 SHALL have port in_ready  out  1  the queue accepts the offered result this cycle.
REQ-006 SHALL have port in_reg  in  3  destination register index.
REQ-007 SHALL have port in_data  in  16  result value.
REQ-008 SHALL have port rf_stall  in  1  the register-file write port is unavailable this cycle.
REQ-009 SHALL have port flush  in  1  discard all queued entries.
REQ-010 SHALL have port write  out  1  register-file write enable.
REQ-011 SHALL have port writeregsel  out  3  register-file write index.
REQ-012 SHALL have port writedata  out  16  register-file write value.
REQ-013 SHALL have ports lookup1sel and lookup2sel  in  3  each a register index to probe.
REQ-014 SHALL have ports hit1 and hit2  out  1  each indicating that a pending entry matches the corresponding lookup.
REQ-015 SHALL have ports hit1data and hit2data  out  16  each the pending value for the corresponding lookup.
REQ-016 SHALL have port count  out  4  current occupancy, 0..DEPTH.

Function
REQ-017 SHALL be a circular FIFO with rd_ptr, wr_ptr (log2 DEPTH bits, wrap DEPTH-1 -> 0), and a count register.
REQ-018 SHALL accept a push when in_valid & in_ready; in_ready = (count < DEPTH) & !flush.
REQ-019 SHALL leave in_ready low when full even if a pop occurs in the same cycle (no full-bypass path).
REQ-020 SHALL drive write = (count != 0) & !rf_stall & !flush, combinationally from head state.
REQ-021 SHALL drive writeregsel and writedata from the head entry at all times; when count == 0 they SHALL be 0.
REQ-022 SHALL pop the head on the rising edge where write == 1.
REQ-023 SHALL change count by +1 on push only, -1 on pop only, and 0 on simultaneous push and pop (non-full case).
REQ-024 SHALL add one cycle of latency: an entry pushed at edge N becomes the head no earlier than cycle N+1, and write is never asserted for it in its push cycle.
REQ-025 SHALL preserve write ordering: entries reach the register file strictly in push order.
REQ-026 SHALL assert hitK when any valid entry, including the head, has in_reg == lookupKsel, for K = 1, 2.
REQ-027 SHALL return in hitKdata the youngest matching entry's data; when hitK == 0, hitKdata SHALL be 0.
REQ-028 SHALL compute the hit logic from queue contents only; an entry being pushed in the current cycle SHALL NOT be visible until the next cycle.
REQ-029 SHALL, on flush, zero count, rd_ptr, and wr_ptr at the next edge, drop any concurrent push, and perform no write that cycle.
REQ-030 SHALL, when rf_stall is held, retain the queue contents; pushes continue until the queue is full.

Reset
REQ-031 SHALL, while rst == 0, immediately force count = 0, rd_ptr = 0, and wr_ptr = 0.
REQ-032 SHALL, while rst == 0, hold write, hit1, hit2, writeregsel, writedata, hit1data, and hit2data at 0, and hold in_ready at 0.
REQ-033 SHALL discard queued entries on reset asserted mid-operation, with no register-file write occurring after assertion.
REQ-034 SHALL NOT require entry storage to be reset; the valid bits derived from the pointers gate all outputs.
REQ-035 SHALL begin operating normally on the first rising edge after rst deasserts.

Verification
REQ-036 Bench SHALL cover: push (r3, 0x1234) with rf_stall = 0 -> next cycle write = 1, writeregsel = 3, writedata = 0x1234; the following cycle count = 0 and write = 0.
REQ-037 Bench SHALL cover: rf_stall = 1, push r1 = 0x0001, r2 = 0x0002, r1 = 0x00AA, r5 = 0x0005, then attempt r6 -> count = 4, in_ready = 0, r6 is not accepted; lookup1sel = 1 -> hit1 = 1, hit1data = 0x00AA; lookup2sel = 7 -> hit2 = 0, hit2data = 0.
REQ-038 Bench SHALL cover: release rf_stall from the REQ-037 state -> writes in order r1/0x0001, r2/0x0002, r1/0x00AA, r5/0x0005 on 4 consecutive cycles, with pointer wrap-around exercised by continued streaming for 10 more pushes.
REQ-039 Bench SHALL cover: count = 2 with push and pop in the same cycle -> count stays 2, and the order is preserved.
REQ-040 Bench SHALL cover: flush asserted together with in_valid at count = 3 -> write = 0 that cycle, count = 0 the next cycle, and the pushed entry never appears on write.
REQ-041 Bench SHALL cover: rst pulsed low mid-drain at count = 3 -> write = 0 and count = 0 immediately with no clock edge; after release, a push of (r4, 0xBEEF) drains normally.

Source files
------------

// File: rtl/wb_queue_if.sv
// Writeback queue bus: producer offer, register-file write port and bypass lookups.
interface wb_queue_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_reg;
  logic [15:0] in_data;
  logic        rf_stall;
  logic        flush;
  logic        write;
  logic [2:0]  writeregsel;
  logic [15:0] writedata;
  logic [2:0]  lookup1sel;
  logic [2:0]  lookup2sel;
  logic        hit1;
  logic        hit2;
  logic [15:0] hit1data;
  logic [15:0] hit2data;
  logic [3:0]  count;

  // Driver side: the pipeline and register file around the queue.
  modport master (
    output in_valid, in_reg, in_data, rf_stall, flush, lookup1sel, lookup2sel,
    input  in_ready, write, writeregsel, writedata, hit1, hit2, hit1data, hit2data, count
  );

  // Queue side.
  modport slave (
    input  in_valid, in_reg, in_data, rf_stall, flush, lookup1sel, lookup2sel,
    output in_ready, write, writeregsel, writedata, hit1, hit2, hit1data, hit2data, count
  );
endinterface

// File: rtl/wb_queue.sv
// Writeback queue: circular FIFO of (reg, data) results draining into the register
// file in push order, with two associative lookups returning the youngest pending value.
module wb_queue #(
  parameter int unsigned DEPTH = 4  // power of two, 2..8
) (
  input logic     clk,
  input logic     rst,
  wb_queue_if.slave bus
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  typedef logic [PtrW-1:0] ptr_t;

  // Entry storage is not reset; validity comes from rd_ptr/count alone.
  logic [2:0]  reg_q  [DEPTH];
  logic [2:0]  reg_d  [DEPTH];
  logic [15:0] data_q [DEPTH];
  logic [15:0] data_d [DEPTH];

  ptr_t       rd_ptr_q, rd_ptr_d;
  ptr_t       wr_ptr_q, wr_ptr_d;
  logic [3:0] count_q, count_d;

  logic        full, empty, push, pop, in_ready, write;
  logic [2:0]  head_reg;
  logic [15:0] head_data;
  logic        hit1, hit2;
  logic [15:0] hit1data, hit2data;
  ptr_t        idx;

  // Handshake and head outputs; in_ready is also held low during reset.
  always_comb begin
    full      = (count_q == 4'(DEPTH));
    empty     = (count_q == 4'd0);
    in_ready  = rst & ~full & ~bus.flush;
    write     = rst & ~empty & ~bus.rf_stall & ~bus.flush;
    push      = bus.in_valid & in_ready;
    pop       = write;
    head_reg  = empty ? 3'd0 : reg_q[rd_ptr_q];
    head_data = empty ? 16'd0 : data_q[rd_ptr_q];
  end

  // Next-state for pointers, occupancy and storage.
  always_comb begin
    reg_d    = reg_q;
    data_d   = data_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = 4'd0;
    end else begin
      if (push) begin
        reg_d[wr_ptr_q]  = bus.in_reg;
        data_d[wr_ptr_q] = bus.in_data;
        wr_ptr_d         = wr_ptr_q + ptr_t'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + ptr_t'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + 4'd1;
        2'b01:   count_d = count_q - 4'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Lookup scan oldest to youngest so the last match wins; only stored entries count.
  always_comb begin
    hit1     = 1'b0;
    hit2     = 1'b0;
    hit1data = 16'd0;
    hit2data = 16'd0;
    idx      = rd_ptr_q;
    for (int k = 0; k < int'(DEPTH); k++) begin
      idx = rd_ptr_q + ptr_t'(k);
      if (4'(k) < count_q) begin
        if (reg_q[idx] == bus.lookup1sel) begin
          hit1     = 1'b1;
          hit1data = data_q[idx];
        end
        if (reg_q[idx] == bus.lookup2sel) begin
          hit2     = 1'b1;
          hit2data = data_q[idx];
        end
      end
    end
  end

  // Pointer and occupancy registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= 4'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    reg_q  <= reg_d;
    data_q <= data_d;
  end

  assign bus.in_ready    = in_ready;
  assign bus.write       = write;
  assign bus.writeregsel = head_reg;
  assign bus.writedata   = head_data;
  assign bus.hit1        = hit1;
  assign bus.hit2        = hit2;
  assign bus.hit1data    = hit1data;
  assign bus.hit2data    = hit2data;
  assign bus.count       = count_q;

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue with hand-computed expectations.
module tb_wb_queue;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  wb_queue_if bus ();

  wb_queue #(.DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] r, input logic [15:0] d);
    bus.in_valid = v;
    bus.in_reg   = r;
    bus.in_data  = d;
  endtask

  logic [2:0]  b_reg [4];
  logic [15:0] b_dat [4];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b0;
    drive(1'b0, 3'd0, 16'd0);
    bus.rf_stall   = 1'b0;
    bus.flush      = 1'b0;
    bus.lookup1sel = 3'd0;
    bus.lookup2sel = 3'd0;

    // Reset state
    #2;
    check("rst_count", 32'(bus.count), 0);
    check("rst_write", 32'(bus.write), 0);
    check("rst_in_ready", 32'(bus.in_ready), 0);
    check("rst_hit1", 32'(bus.hit1), 0);
    check("rst_wdata", 32'(bus.writedata), 0);
    @(posedge clk);
    #3 rst = 1'b1;
    tick();

    // Single push drains one cycle later
    drive(1'b1, 3'd3, 16'h1234);
    bus.lookup1sel = 3'd3;
    #1;
    check("a_in_ready", 32'(bus.in_ready), 1);
    check("a_no_bypass_write", 32'(bus.write), 0);
    check("a_no_bypass_hit", 32'(bus.hit1), 0);
    tick();
    drive(1'b0, 3'd0, 16'd0);
    #1;
    check("a_write", 32'(bus.write), 1);
    check("a_sel", 32'(bus.writeregsel), 3);
    check("a_data", 32'(bus.writedata), 32'h1234);
    check("a_hit1", 32'(bus.hit1), 1);
    check("a_hit1data", 32'(bus.hit1data), 32'h1234);
    tick();
    check("a_count_after", 32'(bus.count), 0);
    check("a_write_after", 32'(bus.write), 0);
    check("a_sel_empty", 32'(bus.writeregsel), 0);
    check("a_data_empty", 32'(bus.writedata), 0);

    // Fill under stall, overflow attempt, lookups
    b_reg = '{3'd1, 3'd2, 3'd1, 3'd5};
    b_dat = '{16'h0001, 16'h0002, 16'h00AA, 16'h0005};
    bus.rf_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, b_reg[i], b_dat[i]);
      #1;
      check("b_stall_write", 32'(bus.write), 0);
      tick();
    end
    drive(1'b1, 3'd6, 16'h0006);
    bus.lookup1sel = 3'd1;
    bus.lookup2sel = 3'd7;
    #1;
    check("b_count_full", 32'(bus.count), 4);
    check("b_in_ready_full", 32'(bus.in_ready), 0);
    check("b_hit1", 32'(bus.hit1), 1);
    check("b_hit1data_youngest", 32'(bus.hit1data), 32'h00AA);
    check("b_hit2", 32'(bus.hit2), 0);
    check("b_hit2data", 32'(bus.hit2data), 0);
    check("b_head_sel", 32'(bus.writeregsel), 1);
    tick();
    drive(1'b0, 3'd0, 16'd0);
    bus.lookup2sel = 3'd6;
    #1;
    check("b_count_held", 32'(bus.count), 4);
    check("b_r6_dropped", 32'(bus.hit2), 0);

    // Release stall: ordered drain
    bus.rf_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("c_write", 32'(bus.write), 1);
      check("c_sel", 32'(bus.writeregsel), 32'(b_reg[i]));
      check("c_data", 32'(bus.writedata), 32'(b_dat[i]));
      check("c_count", 32'(bus.count), 32'(4 - i));
      tick();
    end
    check("c_count_empty", 32'(bus.count), 0);

    // Streaming with wrap-around: each entry written the cycle after its push
    for (int i = 0; i < 11; i++) begin
      drive(i < 10, 3'(i % 8), 16'(16'h0100 + i));
      #1;
      if (i == 0) begin
        check("s_write0", 32'(bus.write), 0);
        check("s_count0", 32'(bus.count), 0);
      end else begin
        check("s_write", 32'(bus.write), 1);
        check("s_sel", 32'(bus.writeregsel), 32'((i - 1) % 8));
        check("s_data", 32'(bus.writedata), 32'(16'h0100 + i - 1));
        check("s_count", 32'(bus.count), 1);
      end
      tick();
    end
    drive(1'b0, 3'd0, 16'd0);
    check("s_count_end", 32'(bus.count), 0);

    // Push and pop together at count 2
    bus.rf_stall = 1'b1;
    drive(1'b1, 3'd1, 16'h0011);
    tick();
    drive(1'b1, 3'd2, 16'h0022);
    tick();
    check("d_count2", 32'(bus.count), 2);
    bus.rf_stall = 1'b0;
    drive(1'b1, 3'd3, 16'h0033);
    #1;
    check("d_write1", 32'(bus.write), 1);
    check("d_sel1", 32'(bus.writeregsel), 1);
    tick();
    drive(1'b0, 3'd0, 16'd0);
    #1;
    check("d_count_stays", 32'(bus.count), 2);
    check("d_sel2", 32'(bus.writeregsel), 2);
    check("d_data2", 32'(bus.writedata), 32'h0022);
    tick();
    check("d_sel3", 32'(bus.writeregsel), 3);
    check("d_data3", 32'(bus.writedata), 32'h0033);
    tick();
    check("d_count_end", 32'(bus.count), 0);

    // Flush with concurrent push at count 3
    bus.rf_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'(i + 1), 16'(16'h00A1 + i));
      tick();
    end
    check("e_count3", 32'(bus.count), 3);
    bus.rf_stall = 1'b0;
    bus.flush    = 1'b1;
    drive(1'b1, 3'd7, 16'h0077);
    #1;
    check("e_flush_write", 32'(bus.write), 0);
    check("e_flush_ready", 32'(bus.in_ready), 0);
    tick();
    bus.flush = 1'b0;
    drive(1'b0, 3'd0, 16'd0);
    bus.lookup1sel = 3'd7;
    #1;
    check("e_count0", 32'(bus.count), 0);
    check("e_write0", 32'(bus.write), 0);
    check("e_no_r7", 32'(bus.hit1), 0);
    tick();
    check("e_write_later", 32'(bus.write), 0);
    check("e_count_later", 32'(bus.count), 0);

    // Asynchronous reset mid-drain at count 3
    b_reg = '{3'd1, 3'd2, 3'd3, 3'd5};
    b_dat = '{16'h00B1, 16'h00B2, 16'h00B3, 16'h00B5};
    bus.rf_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, b_reg[i], b_dat[i]);
      tick();
    end
    drive(1'b0, 3'd0, 16'd0);
    bus.rf_stall = 1'b0;
    #1;
    check("f_write_first", 32'(bus.write), 1);
    tick();
    check("f_count3", 32'(bus.count), 3);
    bus.lookup1sel = 3'd3;
    rst = 1'b0;
    #1;
    check("f_rst_write", 32'(bus.write), 0);
    check("f_rst_count", 32'(bus.count), 0);
    check("f_rst_ready", 32'(bus.in_ready), 0);
    check("f_rst_sel", 32'(bus.writeregsel), 0);
    check("f_rst_data", 32'(bus.writedata), 0);
    check("f_rst_hit1", 32'(bus.hit1), 0);
    tick();
    check("f_rst_write_held", 32'(bus.write), 0);
    #4 rst = 1'b1;
    #1;
    check("f_post_count", 32'(bus.count), 0);
    check("f_post_write", 32'(bus.write), 0);
    drive(1'b1, 3'd4, 16'hBEEF);
    #1;
    check("f_ready", 32'(bus.in_ready), 1);
    tick();
    drive(1'b0, 3'd0, 16'd0);
    #1;
    check("f_beef_write", 32'(bus.write), 1);
    check("f_beef_sel", 32'(bus.writeregsel), 4);
    check("f_beef_data", 32'(bus.writedata), 32'hBEEF);
    tick();
    check("f_end_count", 32'(bus.count), 0);
    check("f_end_write", 32'(bus.write), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
